// File: rtl/soc_misc_wb.sv
// Miscellaneous control slave: boot request, LED blinker settings,
// prescaled tick timer and a watchdog that forces a warm-boot on expiry.
module soc_misc_wb #(
    parameter int         TICK_DIV = 24,
    parameter logic [1:0] WDT_SEL  = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        boot_now,
    output logic [1:0]  boot_sel,
    output logic        led_ena,
    output logic [10:0] led_off,
    output logic [10:0] led_on,
    output logic        tick
);

    logic [11:0] presc;
    logic [31:0] timer;
    logic        wdt_armed;
    logic        wdt_fired;
    logic [23:0] wdt_rem;

    logic        acc_p0;
    logic        wr_p0;
    logic        wr_boot;
    logic        wr_led;
    logic        wr_tmr;
    logic        wr_wdt;
    logic        wdt_fire;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign acc_p0  = wb_cyc & ~wb_ack;
    assign wr_p0   = acc_p0 & wb_we;
    assign wr_boot = wr_p0 && (wb_addr == 3'd0) && !boot_now;
    assign wr_led  = wr_p0 && (wb_addr == 3'd1);
    assign wr_tmr  = wr_p0 && (wb_addr == 3'd2);
    assign wr_wdt  = wr_p0 && (wb_addr == 3'd3);

    assign tick     = (presc == 12'(TICK_DIV - 1));
    // A same-cycle WDT write suppresses both the decrement and the fire.
    assign wdt_fire = tick && wdt_armed && (wdt_rem == 24'd0) && !wr_wdt;

    assign unused_bits = ^{wb_wdata[30:27], wb_wdata[15:11]};

    always_comb begin
        rd_mux = 32'd0;
        case (wb_addr)
            3'd0:    rd_mux = {29'd0, boot_now, boot_sel};
            3'd1:    rd_mux = {led_ena, 4'd0, led_off, 5'd0, led_on};
            3'd2:    rd_mux = timer;
            3'd3:    rd_mux = {wdt_armed, wdt_fired, 6'd0, wdt_rem};
            default: rd_mux = 32'd0;
        endcase
    end

    // Access stage: ack and read data register together; data is zero outside ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'd0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            wb_rdata <= acc_p0 ? rd_mux : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= 12'd0;
            timer <= 32'd0;
        end else if (wr_tmr) begin
            presc <= 12'd0;
            timer <= 32'd0;
        end else if (tick) begin
            presc <= 12'd0;
            timer <= timer + 32'd1;
        end else begin
            presc <= presc + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_armed <= 1'b0;
            wdt_fired <= 1'b0;
            wdt_rem   <= 24'd0;
        end else if (wr_wdt) begin
            wdt_armed <= wb_wdata[31];
            wdt_fired <= 1'b0;
            wdt_rem   <= wb_wdata[23:0];
        end else if (tick && wdt_armed) begin
            if (wdt_rem != 24'd0) begin
                wdt_rem <= wdt_rem - 24'd1;
            end else begin
                wdt_armed <= 1'b0;
                wdt_fired <= 1'b1;
            end
        end
    end

    // Software boot request beats the watchdog; a clearing write does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_now <= 1'b0;
            boot_sel <= 2'b00;
        end else if (wr_boot && wb_wdata[2]) begin
            boot_now <= 1'b1;
            boot_sel <= wb_wdata[1:0];
        end else if (wdt_fire) begin
            boot_now <= 1'b1;
            boot_sel <= WDT_SEL;
        end else if (wr_boot) begin
            boot_now <= 1'b0;
            boot_sel <= wb_wdata[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_ena <= 1'b0;
            led_off <= 11'd0;
            led_on  <= 11'd0;
        end else if (wr_led) begin
            led_ena <= wb_wdata[31];
            led_off <= wb_wdata[26:16];
            led_on  <= wb_wdata[10:0];
        end
    end

endmodule

// File: doc/soc_misc_wb.md
# soc_misc_wb

Wishbone slave for the SoC's miscellaneous control space. It sits between the CPU bus bridge and the boot/LED consumers. It drives `boot_now`/`boot_sel` into the DFU helper and `led_ena`/`led_off`/`led_on` into the LED blinker. It also provides a prescaled microsecond timer and a watchdog that forces a warm-boot if firmware stops servicing it.

## Interface
Parameters:
- `TICK_DIV`, 24: `clk` cycles per timer tick (24 MHz gives 1 µs); legal range 2..4096.
- `WDT_SEL`, 2'b00: `boot_sel` image index forced when the watchdog fires.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_addr`  in  3  word address within the block.
- `wb_wdata`  in  32  write data.
- `wb_rdata`  out  32  read data; valid only while `wb_ack`=1, else 0.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  cycle/select; held until ack.
- `wb_ack`  out  1  single-cycle acknowledge.
- `boot_now`  out  1  warm-boot request; sticky.
- `boot_sel`  out  2  warm-boot image select.
- `led_ena`  out  1  blinker enable.
- `led_off`  out  11  blinker off time.
- `led_on`  out  11  blinker on time.
- `tick`  out  1  one-cycle pulse per prescaler wrap.

## Operation
Register map (word address):
- 0 BOOT
  - Read `{29'b0, boot_now, boot_sel}`.
  - Write `[2]` boot_now, `[1:0]` boot_sel.
  - Once `boot_now`=1, all further BOOT writes are ignored until reset.
- 1 LED
  - Read/write `[31]` ena, `[26:16]` off, `[10:0]` on.
  - Other bits read 0.
- 2 TIMER
  - Read returns the 32-bit tick count.
  - Any write clears both the count and the prescaler to 0.
- 3 WDT
  - Read `{armed, fired, 6'b0, remaining[23:0]}`.
  - Write `[31]` arm, `[23:0]` reload.
  - A write sets `remaining`=reload and `armed`=arm, and clears `fired`.
- 4–7: read 0; writes ignored.

Prescaler:
- Counts 0..TICK_DIV-1.
- `tick`=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- TIMER increments on `tick`, wrapping 0xFFFFFFFF→0.

Watchdog (on `tick` while `armed`=1):
- If `remaining`≠0, decrement `remaining`.
- If `remaining`=0, set `fired`=1 and `armed`=0, and force `boot_now`=1, `boot_sel`=WDT_SEL.

Bus protocol:
- Access edge: the rising edge where `wb_cyc`=1 and `wb_ack`=0.
  - On this edge the write takes effect and `wb_rdata` is registered.
  - `wb_ack` goes to 1 for exactly one cycle after this edge.
- Update rule: `wb_ack <= wb_cyc & ~wb_ack`.
- Back-to-back transactions therefore ack at most every other cycle.
- Exactly one write occurs per transaction.

Priorities for simultaneous events:
- TIMER write vs. tick: the write wins; the count becomes 0, not 1.
- WDT write vs. tick: the write wins; no decrement and no fire that cycle.
- BOOT write with `[2]`=1 vs. watchdog fire: the software value is applied, and `fired` is still set.
- BOOT write with `[2]`=0 vs. watchdog fire: the watchdog values apply.

## Timing
- Reset: every register and output is 0, including `wb_ack`, `wb_rdata`, `tick`, `boot_now`, `boot_sel`, LED outputs, TIMER, prescaler and WDT state.
- Reset asserted mid-transaction drops `wb_ack` immediately; the master must restart the transaction.
- Write → output visible: 1 cycle, i.e. same edge as the access; the output is valid while `wb_ack`=1.
- Read latency: data returned with `wb_ack`, one cycle after `wb_cyc` rises.
- TIMER read returns the value before the access edge.
- Watchdog fire → `boot_now`=1: visible the cycle after the `tick` cycle in which `remaining` was 0.
- Arming with reload=N fires on the (N+1)th tick after the write.

## Test plan
- Reset, then read addresses 0–7: each returns 0 with `wb_ack` high for exactly 1 cycle, 1 cycle after `cyc`.
- Write LED=0x8123_0456: `led_ena`=1, `led_off`=0x123, `led_on`=0x456; readback 0x8123_0456.
- TICK_DIV=24: write TIMER, wait 240 cycles, read: value is 10 (±1 only for access-edge alignment); `tick` pulses every 24 cycles.
- Write BOOT=0x6: `boot_now`=1, `boot_sel`=2. A subsequent write of 0x1 leaves the readback at 0x6.
- Write WDT=0x8000_0003, no further writes: `boot_now` rises on the 4th tick with `boot_sel`=WDT_SEL; read WDT returns 0x4000_0000.
- Re-write WDT=0x8000_0003 in the same cycle a tick occurs: `remaining` reads 3, and the fire happens 4 ticks later, not earlier.
